// File: rtl/spi_flash_pkg.sv
// Shared opcodes and state encoding for the SPI NOR flash responder.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_JEDEC = 8'h9F;
    localparam logic [7:0] OP_RDP   = 8'hAB;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ID,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a registered previous copy for edge pulses.
module spi_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    // Resetting to 0 means a CS already low at reset release is never seen as a fresh edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
            prev <= q;
        end
    end

    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR flash device model: oversamples the link and serves READ / JEDEC ID from a byte memory.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              spi_csb,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              active
);

    logic csb_s, csb_rise, csb_fall;
    logic sck_s, sck_rise, sck_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync_edge u_sync_csb (
        .clk    (clk),
        .resetn (resetn),
        .d      (spi_csb),
        .q      (csb_s),
        .rise   (csb_rise),
        .fall   (csb_fall)
    );

    spi_sync_edge u_sync_sck (
        .clk    (clk),
        .resetn (resetn),
        .d      (spi_clk),
        .q      (sck_s),
        .rise   (sck_rise),
        .fall   (sck_fall)
    );

    spi_sync_edge u_sync_mosi (
        .clk    (clk),
        .resetn (resetn),
        .d      (spi_mosi),
        .q      (mosi_s),
        .rise   (mosi_rise),
        .fall   (mosi_fall)
    );

    assign unused_sync = ^{csb_rise, sck_s, mosi_rise, mosi_fall};

    state_t            state;
    logic [4:0]        bit_cnt;
    logic [ADDR_W-2:0] shreg;
    logic [ADDR_W-1:0] shift_next;
    logic [7:0]        tx;
    logic [1:0]        id_cnt;
    logic              rd_d1;
    logic              byte_done;

    // Shift register contents including the bit sampled on this sck_rise.
    always_comb begin
        shift_next = {shreg, mosi_s};
    end

    assign byte_done = sck_rise && (bit_cnt[2:0] == 3'd7);
    assign active    = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            tx          <= '0;
            id_cnt      <= '0;
            rd_d1       <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
        end else begin
            mem_rd <= 1'b0;
            rd_d1  <= mem_rd;
            if (csb_s) begin
                // Deselect overrides any byte completing in the same cycle.
                state       <= IDLE;
                bit_cnt     <= '0;
                id_cnt      <= '0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else begin
                if (sck_rise) begin
                    bit_cnt <= bit_cnt + 5'd1;
                    shreg   <= shift_next[ADDR_W-2:0];
                end
                unique case (state)
                    IDLE: begin
                        if (csb_fall) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (sck_rise && bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            case (shift_next[7:0])
                                OP_READ:  state <= ADDR;
                                OP_JEDEC: begin
                                    state  <= ID;
                                    tx     <= JEDEC_ID[23:16];
                                    id_cnt <= 2'd1;
                                end
                                OP_RDP:   state <= IGNORE;
                                default:  state <= IGNORE;
                            endcase
                        end
                    end
                    ADDR: begin
                        if (sck_rise && bit_cnt == 5'd23) begin
                            bit_cnt  <= '0;
                            mem_addr <= shift_next;
                            mem_rd   <= 1'b1;
                            state    <= DATA;
                        end
                    end
                    DATA: begin
                        if (rd_d1) begin
                            tx <= mem_rdata;
                        end
                        if (byte_done) begin
                            bit_cnt  <= '0;
                            mem_addr <= mem_addr + ADDR_W'(1);
                            mem_rd   <= 1'b1;
                        end
                    end
                    ID: begin
                        if (byte_done) begin
                            bit_cnt <= '0;
                            case (id_cnt)
                                2'd1:    tx <= JEDEC_ID[15:8];
                                2'd2:    tx <= JEDEC_ID[7:0];
                                default: tx <= 8'hFF;
                            endcase
                            if (id_cnt != 2'd3) begin
                                id_cnt <= id_cnt + 2'd1;
                            end
                        end
                    end
                    IGNORE: begin
                    end
                    default: state <= IDLE;
                endcase
                if (sck_fall && (state == DATA || state == ID)) begin
                    spi_miso    <= tx[7];
                    spi_miso_oe <= 1'b1;
                    tx          <= {tx[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable SPI NOR flash responder: the device side of the single-bit SPI flash link the SoC drives from its flash master (`flash_csb`/`flash_clk`/`flash_io0`/`flash_io1`). It oversamples the serial interface in the system clock domain, decodes READ (0x03), JEDEC ID (0x9F) and RELEASE POWER-DOWN (0xAB), and serves read data from an attached byte-wide memory (BRAM/ROM). It serves as a firmware store for FPGA builds without external flash, and as a flash model for SoC simulation.

## Interface
- `ADDR_W`, 16: memory address width; the 24-bit SPI address is truncated to its low `ADDR_W` bits.
- `JEDEC_ID`, 24'hEF4016: manufacturer/type/capacity bytes returned by 0x9F, MSB byte first.
- `clk`  in  1  system clock; must be ≥ 8× the SPI clock frequency.
- `resetn`  in  1  asynchronous, active-low reset.
- `spi_csb`  in  1  chip select, active low; asynchronous to `clk`.
- `spi_clk`  in  1  SPI clock, mode 0 (idle low); asynchronous to `clk`.
- `spi_mosi`  in  1  serial data from the master (`io0`).
- `spi_miso`  out  1  serial data to the master (`io1`).
- `spi_miso_oe`  out  1  output enable for the `io1` pad tristate.
- `mem_rd`  out  1  single-cycle memory read strobe.
- `mem_addr`  out  ADDR_W  memory byte address, valid with `mem_rd`.
- `mem_rdata`  in  8  memory data; valid exactly 1 `clk` after `mem_rd`.
- `active`  out  1  high while a transaction is in progress (state ≠ IDLE).

## Operation
- `spi_csb`, `spi_clk` and `spi_mosi` each pass through a 2-flop synchronizer. A registered previous copy of `spi_clk` gives the `sck_rise` and `sck_fall` pulses.
- Bits are sampled on `sck_rise` and `spi_miso` shifts on `sck_fall`. All bytes are MSB first.
- **IDLE**: `spi_miso_oe`=0. A synchronized `spi_csb` falling edge clears the bit counter and enters CMD.
- **CMD**: shift in 8 bits. On the 8th `sck_rise`, decode the opcode:
  - 0x03 → ADDR.
  - 0x9F → ID. Load `JEDEC_ID[23:16]`.
  - 0xAB → IGNORE. This is a no-op, since power-down is not modelled.
  - any other value → IGNORE.
- **ADDR**: shift in 24 bits. On the 24th `sck_rise`:
  - set `mem_addr` = addr[ADDR_W-1:0];
  - pulse `mem_rd`;
  - enter DATA.
- **DATA**:
  - One `clk` after `mem_rd`, load `mem_rdata` into the TX shift register.
  - Drive bit 7 on the next `sck_fall`, then shift out on each subsequent `sck_fall`.
  - On the 8th `sck_rise` of each byte, increment `mem_addr` modulo 2^ADDR_W, pulse `mem_rd` and reload.
  - The read continues indefinitely until CS deasserts.
- **ID**: shift out the three `JEDEC_ID` bytes. Every later byte reads 0xFF.
- **IGNORE**: `spi_miso_oe`=0. Wait for CS deassert.
- A synchronized `spi_csb` high in any state returns to IDLE on the next `clk`. It also clears the counters and drops `spi_miso_oe`, with no partial-byte side effects.
- `spi_miso_oe`=1 only in DATA/ID, starting from the first `sck_fall` at which a data bit is driven.

## Timing
- Reset values: `spi_miso`=0, `spi_miso_oe`=0, `mem_rd`=0, `mem_addr`=0, `active`=0, state IDLE.
- Input-to-decision latency is 3 `clk` (2 sync + 1 edge register). Output change after an `sck_fall` pulse: 1 `clk`.
- The memory fetch completes within 2 `clk` of its `sck_rise`, which is always before the next `sck_fall` given the ≥ 8× ratio.
- `mem_rd` fires at most once per byte, and never outside DATA.
- Simultaneous CS deassert and byte completion: CS wins, and no `mem_rd` is issued.
- Asserting `resetn` mid-transaction forces all reset values immediately. After release, the block waits for a fresh `spi_csb` falling edge and does not resume mid-frame.
- Address wrap: 0x…FFFF followed by the next byte reads `mem_addr`=0.

## Structure
- Package `spi_flash_pkg` holds:
  - opcode constants `OP_READ`, `OP_JEDEC`, `OP_RDP`;
  - state enum IDLE/CMD/ADDR/DATA/ID/IGNORE.
- Sub-module `spi_sync_edge`: 2-flop synchronizer plus optional edge-detect outputs. Three instances, one each for csb, clk and mosi.

## Test plan
- **Basic read.** Memory `mem[i]`=i[7:0], `clk`=100 MHz, SCK=10 MHz. Send 0x03, 0x000010, then read 4 bytes → master receives 0x10 0x11 0x12 0x13, and `mem_addr` steps 0x10→0x13.
- **JEDEC ID.** Send 0x9F, then read 4 bytes → 0xEF 0x40 0x16 0xFF.
- **Unknown opcode.** Send 0x5A, then clock 16 bits → `spi_miso_oe` stays 0 and `mem_rd` never pulses.
- **Address wrap.** With `ADDR_W`=16, send 0x03, 0x00FFFF, then read 2 bytes → `mem[0xFFFF]` then `mem[0x0000]`.
- **Abort mid-byte.** Raise CS after 3 data bits → `active` and `spi_miso_oe` fall within 4 `clk`. A following 0x03 read at 0x000020 returns 0x20.
- **Reset mid-transaction.** Assert `resetn`=0 during ADDR, release, then start a new read at 0x000005 → returns 0x05, and all outputs read their reset values while in reset.
